sol32_data_responder: RTL

SOL32_DATA_RESPONDER -- requirements
Module: sol32_data_responder

---
 rtl/sol32_pkg.sv | 28 ++
 rtl/sol32_timer.sv | 46 ++++
 rtl/sol32_data_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/sol32_pkg.sv
// Shared constants for the sol32 data responder: MMIO map, IRQ bit positions
// and the TIMER_CTRL field layout.
package sol32_pkg;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;

  localparam logic [4:0] OFF_TIMER_COUNT   = 5'h00;
  localparam logic [4:0] OFF_TIMER_COMPARE = 5'h04;
  localparam logic [4:0] OFF_TIMER_CTRL    = 5'h08;
  localparam logic [4:0] OFF_IRQ_STATUS    = 5'h0C;
  localparam logic [4:0] OFF_FAULT_ADDR    = 5'h10;
  localparam logic [4:0] OFF_IRQ_MASK      = 5'h14;

  localparam int IRQ_TIMER_BIT = 0;
  localparam int IRQ_FAULT_BIT = 1;

  // LSB first in the register: bit0 run, bit1 irq_en, bit2 auto_clr
  typedef struct packed {
    logic auto_clr;
    logic irq_en;
    logic run;
  } timer_ctrl_t;

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31:5] == MMIO_BASE[31:5];
  endfunction

endpackage

// File: rtl/sol32_timer.sv
// Free-running up-counter with compare match; software writes to the count
// take priority over the increment and the auto-clear reload.
module sol32_timer
  import sol32_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_count,
  input  logic        i_wr_compare,
  input  logic        i_wr_ctrl,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output timer_ctrl_t o_ctrl,
  output logic        o_match
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  timer_ctrl_t r_ctrl;

  assign o_match   = r_ctrl.run && (r_count == r_compare);
  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ctrl    = r_ctrl;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count   <= '0;
      r_compare <= '0;
      r_ctrl    <= '0;
    end else begin
      if (i_wr_count)
        r_count <= i_wdata;
      else if (o_match && r_ctrl.auto_clr)
        r_count <= '0;
      else if (r_ctrl.run)
        r_count <= r_count + 32'd1;
      if (i_wr_compare)
        r_compare <= i_wdata;
      if (i_wr_ctrl)
        r_ctrl <= timer_ctrl_t'(i_wdata[2:0]);
    end
  end

endmodule

// File: rtl/sol32_data_responder.sv
// Data-side responder for the sol32 core: word RAM, MMIO timer/IRQ block and
// privilege fault capture. Timer compiled in only when SOL32_TIMER_EN is defined.
module sol32_data_responder
  import sol32_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] USER_LIMIT = 32'h0000_0800
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Mode,
  input  logic [31:0] MemoryAddress,
  input  logic        WriteEnable,
  input  logic [31:0] DataOut,
  output logic [31:0] DataIn,
  output logic        Interrupt
);

  localparam int          AW          = $clog2(RAM_WORDS);
  localparam logic [29:0] RAM_WORDS_W = 30'(RAM_WORDS);

  logic [31:0] r_ram [RAM_WORDS];
  logic [1:0]  r_irq_status;
  logic [1:0]  r_irq_mask;
  logic [31:0] r_fault_addr;

  logic          w_ram_hit;
  logic          w_mmio_hit;
  logic          w_fault;
  logic          w_wr;
  logic          w_wr_mmio;
  logic [4:0]    w_off;
  logic [AW-1:0] w_ram_idx;
  logic [1:0]    w_set;
  logic [1:0]    w_clr;
  logic [31:0]   w_tcount;
  logic [31:0]   w_tcompare;
  timer_ctrl_t   w_tctrl;
  logic          w_tmatch;

  assign w_ram_hit  = MemoryAddress[31:2] < RAM_WORDS_W;
  assign w_mmio_hit = is_mmio(MemoryAddress);
  // No read strobe on this bus, so every presented address counts as an access
  assign w_fault    = !(w_ram_hit || w_mmio_hit) || (Mode && (MemoryAddress >= USER_LIMIT));
  assign w_wr       = WriteEnable && !w_fault;
  assign w_wr_mmio  = w_wr && w_mmio_hit;
  assign w_off      = {MemoryAddress[4:2], 2'b00};
  assign w_ram_idx  = MemoryAddress[AW+1:2];

`ifdef SOL32_TIMER_EN
  sol32_timer u_timer (
    .i_clk        (Clock),
    .i_rst_n      (Reset),
    .i_wr_count   (w_wr_mmio && (w_off == OFF_TIMER_COUNT)),
    .i_wr_compare (w_wr_mmio && (w_off == OFF_TIMER_COMPARE)),
    .i_wr_ctrl    (w_wr_mmio && (w_off == OFF_TIMER_CTRL)),
    .i_wdata      (DataOut),
    .o_count      (w_tcount),
    .o_compare    (w_tcompare),
    .o_ctrl       (w_tctrl),
    .o_match      (w_tmatch)
  );
`else
  assign w_tcount   = '0;
  assign w_tcompare = '0;
  assign w_tctrl    = '0;
  assign w_tmatch   = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (w_wr && w_ram_hit)
      r_ram[w_ram_idx] <= DataOut;
  end

  always_comb begin
    DataIn = '0;
    if (!w_fault) begin
      if (w_ram_hit) begin
        DataIn = r_ram[w_ram_idx];
      end else if (w_mmio_hit) begin
        case (w_off)
          OFF_TIMER_COUNT:   DataIn = w_tcount;
          OFF_TIMER_COMPARE: DataIn = w_tcompare;
          OFF_TIMER_CTRL:    DataIn = {29'd0, w_tctrl};
          OFF_IRQ_STATUS:    DataIn = {30'd0, r_irq_status};
          OFF_FAULT_ADDR:    DataIn = r_fault_addr;
          OFF_IRQ_MASK:      DataIn = {30'd0, r_irq_mask};
          default:           DataIn = '0;
        endcase
      end
    end
  end

  // bit1 fault, bit0 timer; a new set beats a simultaneous write-1-to-clear
  assign w_set = {w_fault, w_tmatch};
  assign w_clr = (w_wr_mmio && (w_off == OFF_IRQ_STATUS)) ? DataOut[1:0] : 2'b00;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_irq_status <= '0;
      r_irq_mask   <= '0;
      r_fault_addr <= '0;
    end else begin
      r_irq_status <= (r_irq_status & ~w_clr) | w_set;
      if (w_fault)
        r_fault_addr <= MemoryAddress;
      if (w_wr_mmio && (w_off == OFF_IRQ_MASK))
        r_irq_mask <= DataOut[1:0];
    end
  end

  assign Interrupt = (r_irq_status[IRQ_FAULT_BIT] & r_irq_mask[IRQ_FAULT_BIT])
                   | (r_irq_status[IRQ_TIMER_BIT] & r_irq_mask[IRQ_TIMER_BIT] & w_tctrl.irq_en);

endmodule
